// File: rtl/alu_share_arbiter_if.sv
// Client-side bus of the shared-ALU arbiter: two request/operand channels
// plus the per-requester response handshake.
interface alu_share_arbiter_if;
  logic [1:0] req;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [2:0] fn0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [2:0] fn1;
  logic [1:0] gnt;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_ready;

  // Requester side
  modport master (
    output req, a0, b0, fn0, a1, b1, fn1, rsp_ready,
    input  gnt, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req, a0, b0, fn0, a1, b1, fn1, rsp_ready,
    output gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered toward the ALU, the result is registered back and
// returned through a per-requester valid/ready response.
module alu_share_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  alu_share_arbiter_if.slave   bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_fn,
  input  logic [7:0]           alu_c,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_gnt;
  logic [1:0]       r_valid;
  logic [7:0]       r_data;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [2:0]       r_fn;
  logic [CNT_W-1:0] r_ops;
  logic             w_winner;

  // Winner: the sole requester, or the one that did not own the last op
  always_comb begin
    w_winner = bus.req[1];
    if (bus.req == 2'b11) w_winner = ~r_last;
  end

  // Arbitration / execution / response sequencing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_fn    <= '0;
      r_ops   <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            r_a     <= w_winner ? bus.a1  : bus.a0;
            r_b     <= w_winner ? bus.b1  : bus.b0;
            r_fn    <= w_winner ? bus.fn1 : bus.fn0;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_cnt   <= CW'(EXEC_CYCLES - 1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_data  <= alu_c;
            r_valid <= r_owner ? 2'b10 : 2'b01;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_valid <= '0;
            r_ops   <= r_ops + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output mapping
  always_comb begin
    bus.gnt       = r_gnt;
    bus.rsp_valid = r_valid;
    bus.rsp_data  = r_data;
    alu_a         = r_a;
    alu_b         = r_b;
    alu_fn        = r_fn;
    op_count      = r_ops;
    busy          = (r_state == S_EXEC) || (r_state == S_RESP);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (EXEC_CYCLES 1 and 3) driven by
// the same stimulus, each checked every cycle against a transaction model,
// plus directed constant checks for the key scenarios.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [1:0] req, rdy;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] fn0, fn1;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arbiter_if bus1 ();
  alu_share_arbiter_if bus3 ();

  assign bus1.req = req;  assign bus3.req = req;
  assign bus1.a0  = a0;   assign bus3.a0  = a0;
  assign bus1.b0  = b0;   assign bus3.b0  = b0;
  assign bus1.fn0 = fn0;  assign bus3.fn0 = fn0;
  assign bus1.a1  = a1;   assign bus3.a1  = a1;
  assign bus1.b1  = b1;   assign bus3.b1  = b1;
  assign bus1.fn1 = fn1;  assign bus3.fn1 = fn1;
  assign bus1.rsp_ready = rdy;
  assign bus3.rsp_ready = rdy;

  // Reference ALU; code 5 is treated as unsupported
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] fn);
    case (fn)
      3'd0:    return {4'h0, a & b};
      3'd1:    return {4'h0, a | b};
      3'd2:    return {4'h0, a ^ b};
      3'd3:    return {4'h0, a} - {4'h0, b};
      3'd4:    return {4'h0, a} * {4'h0, b};
      3'd6:    return {4'h0, a} + {4'h0, b};
      3'd7:    return {4'h0, a} + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  logic [3:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [2:0] alu_fn1, alu_fn3;
  logic [7:0] alu_c1, alu_c3, oc1, oc3;
  logic       busy1, busy3;

  assign alu_c1 = alu_f(alu_a1, alu_b1, alu_fn1);
  assign alu_c3 = alu_f(alu_a3, alu_b3, alu_fn3);

  alu_share_arbiter #(.EXEC_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_fn(alu_fn1), .alu_c(alu_c1),
    .busy(busy1), .op_count(oc1)
  );

  alu_share_arbiter #(.EXEC_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .resetn(resetn), .bus(bus3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_fn(alu_fn3), .alu_c(alu_c3),
    .busy(busy3), .op_count(oc3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // Per instance: an op is in flight from its grant edge; m_k counts edges
  // since the grant; the response is pending once m_k reaches EXEC_CYCLES.
  function automatic int ex(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic win(input logic [1:0] r, input logic last);
    return (r == 2'b11) ? ~last : r[1];
  endfunction

  logic       m_act [2];
  int         m_k   [2];
  logic       m_own [2];
  logic       m_last[2];
  logic [3:0] m_a   [2];
  logic [3:0] m_b   [2];
  logic [2:0] m_fn  [2];
  logic [7:0] m_data[2];
  logic [7:0] m_cnt [2];
  int         done1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_k[i] <= 0; m_own[i] <= 1'b0; m_last[i] <= 1'b1;
        m_a[i] <= '0; m_b[i] <= '0; m_fn[i] <= '0; m_data[i] <= '0; m_cnt[i] <= '0;
      end
      done1 <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (m_k[i] < ex(i)) begin
            if (m_k[i] == ex(i) - 1) m_data[i] <= alu_f(m_a[i], m_b[i], m_fn[i]);
            m_k[i] <= m_k[i] + 1;
          end else if (rdy[m_own[i]]) begin
            m_act[i] <= 1'b0;
            m_cnt[i] <= m_cnt[i] + 8'd1;
            if (i == 0) done1 <= done1 + 1;
          end
        end else if (req != 2'b00) begin
          m_act[i]  <= 1'b1;
          m_k[i]    <= 0;
          m_own[i]  <= win(req, m_last[i]);
          m_last[i] <= win(req, m_last[i]);
          m_a[i]    <= win(req, m_last[i]) ? a1  : a0;
          m_b[i]    <= win(req, m_last[i]) ? b1  : b0;
          m_fn[i]   <= win(req, m_last[i]) ? fn1 : fn0;
        end
      end
    end
  end

  task automatic check_dut(input string nm, input int i, input logic [1:0] g,
                           input logic [1:0] v, input logic [7:0] d,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] fn, input logic bz, input logic [7:0] oc);
    logic [1:0] onehot;
    logic [1:0] eg, ev;
    onehot = m_own[i] ? 2'b10 : 2'b01;
    eg = (m_act[i] && m_k[i] == 0)      ? onehot : 2'b00;
    ev = (m_act[i] && m_k[i] >= ex(i))  ? onehot : 2'b00;
    chk({nm, "_gnt"},   g,  eg);
    chk({nm, "_valid"}, v,  ev);
    chk({nm, "_data"},  d,  m_data[i]);
    chk({nm, "_alu_a"}, a,  m_a[i]);
    chk({nm, "_alu_b"}, b,  m_b[i]);
    chk({nm, "_alu_fn"}, fn, m_fn[i]);
    chk({nm, "_busy"},  bz, m_act[i]);
    chk({nm, "_opcnt"}, oc, m_cnt[i]);
    chk({nm, "_gnt_1hot"},   $onehot0(g), 1);
    chk({nm, "_valid_1hot"}, $onehot0(v), 1);
    chk({nm, "_gnt_vs_valid"}, (|g) && (|v), 0);
  endtask

  always @(negedge clk) begin
    check_dut("d1", 0, bus1.gnt, bus1.rsp_valid, bus1.rsp_data, alu_a1, alu_b1, alu_fn1, busy1, oc1);
    check_dut("d3", 1, bus3.gnt, bus3.rsp_valid, bus3.rsp_data, alu_a3, alu_b3, alu_fn3, busy3, oc3);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; req = 2'b00; rdy = 2'b00;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic pulse_ready(input logic [1:0] r);
    @(posedge clk); #1 rdy = r;
    @(posedge clk); #1 rdy = 2'b00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int guard;
    resetn = 1'b0; req = 2'b11; rdy = 2'b00;
    a0 = 4'd1; b0 = 4'd2; fn0 = 3'd6; a1 = 4'd7; b1 = 4'd7; fn1 = 3'd6;

    // Reset held with both requesting: everything stays zero
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_gnt1", bus1.gnt, 0);
      chk("rst_gnt3", bus3.gnt, 0);
      chk("rst_valid1", bus1.rsp_valid, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_alu_a1", alu_a1, 0);
      chk("rst_opcnt1", oc1, 0);
    end
    @(posedge clk); #1 resetn = 1'b1; req = 2'b00;

    // Single op from requester 0: 3 + 5
    @(posedge clk); #1 req = 2'b01; a0 = 4'd3; b0 = 4'd5; fn0 = 3'b110;
    @(negedge clk); chk("s_gnt_k", bus1.gnt, 0);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    chk("s_gnt", bus1.gnt, 2'b01);
    chk("s_alu_a", alu_a1, 4'd3);
    chk("s_alu_b", alu_b1, 4'd5);
    @(negedge clk);
    chk("s_valid", bus1.rsp_valid, 2'b01);
    chk("s_data", bus1.rsp_data, 8'h08);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s_hold_valid", bus1.rsp_valid, 2'b01);
      chk("s_hold_data", bus1.rsp_data, 8'h08);
    end
    pulse_ready(2'b01);
    @(negedge clk);
    chk("s_opcnt1", oc1, 8'd1);
    chk("s_opcnt3", oc3, 8'd1);
    chk("s_valid_clr", bus1.rsp_valid, 0);

    // Contention: grants alternate 0,1,0,1
    do_reset();
    #1 req = 2'b11; rdy = 2'b11;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      @(negedge clk);
      while (bus1.gnt == 2'b00 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("ct_timeout", cyc < 20, 1);
      chk("ct_order", bus1.gnt, (n % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1 req = 2'b00;
    repeat (6) @(posedge clk);
    #1 rdy = 2'b00;

    // EXEC_CYCLES=3 latency: requester 1, F + 1
    do_reset();
    @(posedge clk); #1 req = 2'b10; a1 = 4'hF; b1 = 4'd1; fn1 = 3'b111;
    @(posedge clk); #1 req = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) chk("e3_wait", bus3.rsp_valid, 0);
      else begin
        chk("e3_valid", bus3.rsp_valid, 2'b10);
        chk("e3_data", bus3.rsp_data, 8'h10);
        chk("e1_data", bus1.rsp_data, 8'h10);
      end
    end
    pulse_ready(2'b01);
    @(negedge clk); chk("e3_wrong_ready", bus3.rsp_valid, 2'b10);
    pulse_ready(2'b10);
    @(negedge clk); chk("e3_opcnt", oc3, 8'd1);

    // Reset in the middle of EXEC discards the op
    do_reset();
    @(posedge clk); #1 req = 2'b01; a0 = 4'd2; b0 = 4'd2; fn0 = 3'd6;
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk); chk("mr_busy3", busy3, 0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mr_valid3", bus3.rsp_valid, 0);
      chk("mr_opcnt3", oc3, 0);
      chk("mr_opcnt1", oc1, 0);
    end
    @(posedge clk); #1 req = 2'b01; a0 = 4'd9; b0 = 4'd4; fn0 = 3'd3;
    @(posedge clk); #1 req = 2'b00;
    cyc = 0;
    @(negedge clk);
    while (bus3.rsp_valid == 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mr_timeout", cyc < 20, 1);
    chk("mr_data", bus3.rsp_data, 8'h05);
    pulse_ready(2'b11);

    // Random traffic until 256 ops complete on the EXEC_CYCLES=1 instance
    do_reset();
    guard = 0;
    while (done1 < 256 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (done1 < 256) begin
        req = 2'($urandom_range(0, 3));
        rdy = 2'($urandom_range(0, 3));
        a0  = 4'($urandom); b0 = 4'($urandom); fn0 = 3'($urandom);
        a1  = 4'($urandom); b1 = 4'($urandom); fn1 = 3'($urandom);
      end
    end
    req = 2'b00; rdy = 2'b00;
    @(negedge clk);
    chk("wrap_done", done1, 256);
    chk("wrap_opcnt", oc1, 8'd0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
